// File: rtl/stopwatch_bcd_pkg.sv
// stopwatch_pkg: shared widths, digit limits, FSM encoding and a BCD helper
// for the stopwatch_bcd block.
package stopwatch_pkg;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] DIGIT_MAX_9 = 4'd9;
  localparam logic [BCD_W-1:0] DIGIT_MAX_5 = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Convert a binary value (clamped to 0..99) into two packed BCD digits {tens, ones}.
  function automatic logic [2*BCD_W-1:0] bin_to_bcd2(input int value);
    int clipped;
    clipped = (value < 0) ? 0 : ((value > 99) ? 99 : value);
    return {BCD_W'(clipped / 10), BCD_W'(clipped % 10)};
  endfunction

endpackage

// File: rtl/stopwatch_bcd_if.sv
// stopwatch_bcd_if: control inputs and BCD display outputs of the stopwatch.
// The lap / lap_active pair exists only when LAP_HOLD_EN is defined.
interface stopwatch_bcd_if;
  import stopwatch_pkg::*;

  logic             tick_in;
  logic             start_stop;
  logic             clear;
  logic [BCD_W-1:0] cs_ones;
  logic [BCD_W-1:0] cs_tens;
  logic [BCD_W-1:0] sec_ones;
  logic [BCD_W-1:0] sec_tens;
  logic [BCD_W-1:0] min_ones;
  logic [BCD_W-1:0] min_tens;
  logic             running;
  logic             wrap;

`ifdef LAP_HOLD_EN
  logic             lap;
  logic             lap_active;

  modport master (
    output tick_in, start_stop, clear, lap,
    input  cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens,
    input  running, wrap, lap_active
  );

  modport slave (
    input  tick_in, start_stop, clear, lap,
    output cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens,
    output running, wrap, lap_active
  );
`else
  modport master (
    output tick_in, start_stop, clear,
    input  cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens,
    input  running, wrap
  );

  modport slave (
    input  tick_in, start_stop, clear,
    output cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens,
    output running, wrap
  );
`endif

endinterface

// File: rtl/stopwatch_bcd_digit.sv
// bcd_digit: one decade counter of the stopwatch carry chain.
// Counts 0..LIMIT on inc, wraps to 0 and raises carry on the wrapping cycle.
// clr has priority over inc so a clear or terminal rollover always wins.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [BCD_W-1:0] LIMIT = DIGIT_MAX_9
) (
  input  logic             clk_50mhz,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  // Digit register: reset/clear to zero, otherwise step and wrap at LIMIT.
  always_ff @(posedge clk_50mhz) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == LIMIT) ? '0 : q + 1'b1;
    end
  end

  assign carry = inc & (q == LIMIT);

endmodule

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: MM:SS.cc stopwatch in six BCD digits driven by the rising
// edge of a 100 Hz level on tick_in (same clock domain as clk_50mhz).
// Build option: define LAP_HOLD_EN to add the lap-hold display freeze.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int MINUTES_MAX      = 59,
  parameter int TICK_SYNC_STAGES = 0
) (
  input logic            clk_50mhz,
  input logic            rst,
  stopwatch_bcd_if.slave bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_PAUSE = PAUSE;

  // Terminal minute value as two BCD digits, compared as a pair.
  localparam logic [2*BCD_W-1:0] MIN_LAST = bin_to_bcd2(MINUTES_MAX);

  logic [1:0]         state;
  logic               tick_s;
  logic               tick_q;
  logic               tick_rise;
  logic               count_en;
  logic               wrap_q;

  logic [BCD_W-1:0]   cs_ones_q;
  logic [BCD_W-1:0]   cs_tens_q;
  logic [BCD_W-1:0]   sec_ones_q;
  logic [BCD_W-1:0]   sec_tens_q;
  logic [BCD_W-1:0]   min_ones_q;
  logic [BCD_W-1:0]   min_tens_q;

  logic               cs_ones_c;
  logic               cs_tens_c;
  logic               sec_ones_c;
  logic               sec_tens_c;
  logic               min_ones_c;
  logic               min_tens_c;

  logic               min_at_last;
  logic               min_roll;
  logic               min_clr;

  logic [6*BCD_W-1:0] live;
  logic [6*BCD_W-1:0] shown;

  generate
    if (TICK_SYNC_STAGES == 0) begin : g_no_sync
      assign tick_s = bus.tick_in;
    end else begin : g_sync
      logic [TICK_SYNC_STAGES-1:0] sync_q;

      // Delay tick_in through the configured number of flops.
      always_ff @(posedge clk_50mhz) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= bus.tick_in;
          for (int i = 1; i < TICK_SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign tick_s = sync_q[TICK_SYNC_STAGES-1];
    end
  endgenerate

  // Previous tick level, so a high level produces exactly one enable cycle.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_s;
    end
  end

  assign tick_rise = tick_s & ~tick_q;

  // The tick is judged against the current state, before any start_stop
  // transition takes effect; clear blanks it entirely.
  assign count_en = tick_rise & (state == S_RUN) & ~bus.clear;

  // Run/pause FSM: clear returns to IDLE from anywhere, start_stop toggles.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state <= S_IDLE;
    end else if (bus.clear) begin
      state <= S_IDLE;
    end else if (bus.start_stop) begin
      case (state)
        S_IDLE:  state <= S_RUN;
        S_RUN:   state <= S_PAUSE;
        S_PAUSE: state <= S_RUN;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.running = (state == S_RUN);

  bcd_digit #(.LIMIT(DIGIT_MAX_9)) u_cs_ones (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .clr       (bus.clear),
    .inc       (count_en),
    .q         (cs_ones_q),
    .carry     (cs_ones_c)
  );

  bcd_digit #(.LIMIT(DIGIT_MAX_9)) u_cs_tens (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .clr       (bus.clear),
    .inc       (cs_ones_c),
    .q         (cs_tens_q),
    .carry     (cs_tens_c)
  );

  bcd_digit #(.LIMIT(DIGIT_MAX_9)) u_sec_ones (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .clr       (bus.clear),
    .inc       (cs_tens_c),
    .q         (sec_ones_q),
    .carry     (sec_ones_c)
  );

  bcd_digit #(.LIMIT(DIGIT_MAX_5)) u_sec_tens (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .clr       (bus.clear),
    .inc       (sec_ones_c),
    .q         (sec_tens_q),
    .carry     (sec_tens_c)
  );

  // The minutes pair rolls over at MINUTES_MAX rather than at 99; the natural
  // tens carry only fires at 99, which is also the largest legal terminal.
  assign min_at_last = (min_tens_q == MIN_LAST[2*BCD_W-1:BCD_W]) &&
                       (min_ones_q == MIN_LAST[BCD_W-1:0]);
  assign min_roll    = (sec_tens_c & min_at_last) | min_tens_c;
  assign min_clr     = bus.clear | min_roll;

  bcd_digit #(.LIMIT(DIGIT_MAX_9)) u_min_ones (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .clr       (min_clr),
    .inc       (sec_tens_c),
    .q         (min_ones_q),
    .carry     (min_ones_c)
  );

  bcd_digit #(.LIMIT(DIGIT_MAX_9)) u_min_tens (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .clr       (min_clr),
    .inc       (min_ones_c),
    .q         (min_tens_q),
    .carry     (min_tens_c)
  );

  // One-cycle rollover flag aligned with the digits showing 00:00.00.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= min_roll & ~bus.clear;
    end
  end

  assign bus.wrap = wrap_q;

  assign live = {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q, cs_tens_q, cs_ones_q};

`ifdef LAP_HOLD_EN
  logic               lap_q;
  logic [6*BCD_W-1:0] held;

  // Lap in RUN toggles the hold; entering it snapshots the live digits.
  always_ff @(posedge clk_50mhz) begin
    if (rst || bus.clear) begin
      lap_q <= 1'b0;
      held  <= '0;
    end else if (bus.lap && (state == S_RUN)) begin
      lap_q <= ~lap_q;
      if (!lap_q) begin
        held <= live;
      end
    end
  end

  assign bus.lap_active = lap_q;
  assign shown          = lap_q ? held : live;
`else
  assign shown = live;
`endif

  assign {bus.min_tens, bus.min_ones, bus.sec_tens,
          bus.sec_ones, bus.cs_tens,  bus.cs_ones} = shown;

endmodule
